// File: rtl/top.sv
// Four-lane slide-switch debouncer: each switch bit is synchronized, then only
// accepted once it has disagreed with the debounced state for DEBOUNCE_CYCLES edges.

module top_lane #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CW              = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_led
);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_sw;
            r_s2 <= r_s1;
            // Any agreement restarts the run, so short glitches never accumulate.
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_led = r_stable;
endmodule

module top #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    output logic [3:0] led
);
    localparam int NUM_LANES = 4;
    // Counter must hold DEBOUNCE_CYCLES-1; keep at least one bit for the degenerate case.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        top_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CW             (CW)
        ) u_lane (
            .i_clk(clk),
            .i_rst(rst),
            .i_sw (sw[gi]),
            .o_led(led[gi])
        );
    end
endmodule

// File: tb/tb_top.sv
// Self-checking bench for the switch debouncer: default-parameter instance plus a
// DEBOUNCE_CYCLES=1 instance, expected led values queued per cycle and popped after each edge.

module tb_top;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw  = 4'h0;
    logic [3:0] sw1 = 4'h0;
    logic [3:0] led;
    logic [3:0] led1;

    int checks = 0;
    int errors = 0;
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    top dut (
        .clk(clk),
        .rst(rst),
        .sw (sw),
        .led(led)
    );

    top #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk),
        .rst(rst),
        .sw (sw1),
        .led(led1)
    );

    task automatic test_reset();
        logic [3:0] exp;
        rst = 1'b1;
        sw  = 4'hF;
        sw1 = 4'hF;
        for (int i = 0; i < 4; i++) sb.push_back(4'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp = sb.pop_front();
            checks++;
            if (led !== exp) begin
                errors++;
                $display("FAIL reset cyc %0d: led=%b expected %b", i, led, exp);
            end
            checks++;
            if (led1 !== exp) begin
                errors++;
                $display("FAIL reset_p1 cyc %0d: led1=%b expected %b", i, led1, exp);
            end
        end
        sw  = 4'h0;
        sw1 = 4'h0;
        rst = 1'b0;
    endtask

    task automatic test_idle();
        logic [3:0] exp;
        for (int i = 0; i < 20; i++) sb.push_back(4'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sw = 4'h0;
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (led !== exp) begin
                errors++;
                $display("FAIL idle cyc %0d: led=%b expected %b", i, led, exp);
            end
        end
    endtask

    // Held value V from debounced state S: S through edge k+4, V from edge k+5.
    task automatic test_latency();
        logic [3:0] exp;
        for (int i = 0; i < 10; i++) sb.push_back(i < 5 ? 4'h0 : 4'hA);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sw = 4'hA;
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (led !== exp) begin
                errors++;
                $display("FAIL latency edge k+%0d: led=%b expected %b", i, led, exp);
            end
        end
    endtask

    task automatic test_sequence();
        logic [3:0] exp;
        logic [3:0] vals [2];
        logic [3:0] prev;
        vals[0] = 4'h5;
        vals[1] = 4'hF;
        prev = 4'hA;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 10; i++) sb.push_back(i < 5 ? prev : vals[s]);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                sw = vals[s];
                @(posedge clk); #1;
                exp = sb.pop_front();
                checks++;
                if (led !== exp) begin
                    errors++;
                    $display("FAIL sequence step %0d edge k+%0d: led=%b expected %b", s, i, led, exp);
                end
            end
            prev = vals[s];
        end
    endtask

    // led is 1111 on entry; reset must clear it between edges, then re-debounce 1111.
    task automatic test_async_reset();
        logic [3:0] exp;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (led !== 4'h0) begin
            errors++;
            $display("FAIL async_reset: led=%b expected 0000 before any edge", led);
        end
        @(posedge clk); #1;
        checks++;
        if (led !== 4'h0) begin
            errors++;
            $display("FAIL async_reset held: led=%b expected 0000", led);
        end
        for (int i = 0; i < 10; i++) sb.push_back(i < 5 ? 4'h0 : 4'hF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rst = 1'b0;
            sw  = 4'hF;
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (led !== exp) begin
                errors++;
                $display("FAIL async_reset release edge k+%0d: led=%b expected %b", i, led, exp);
            end
        end
        for (int i = 0; i < 10; i++) sb.push_back(i < 5 ? 4'hF : 4'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sw = 4'h0;
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (led !== exp) begin
                errors++;
                $display("FAIL async_reset clear edge k+%0d: led=%b expected %b", i, led, exp);
            end
        end
    endtask

    // 1111 for 3 cycles, reset pulse aborts the count, release with 1111 still applied.
    task automatic test_reset_midcount();
        logic [3:0] exp;
        for (int i = 0; i < 5; i++) sb.push_back(4'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sw  = 4'hF;
            rst = (i >= 3);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (led !== exp) begin
                errors++;
                $display("FAIL midcount pre cyc %0d: led=%b expected %b", i, led, exp);
            end
        end
        for (int i = 0; i < 10; i++) sb.push_back(i < 5 ? 4'h0 : 4'hF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (led !== exp) begin
                errors++;
                $display("FAIL midcount release edge k+%0d: led=%b expected %b", i, led, exp);
            end
        end
        for (int i = 0; i < 10; i++) sb.push_back(i < 5 ? 4'hF : 4'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sw = 4'h0;
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (led !== exp) begin
                errors++;
                $display("FAIL midcount clear edge k+%0d: led=%b expected %b", i, led, exp);
            end
        end
    endtask

    // Pulses of 2,3 cycles are rejected; 4 (exactly the threshold) and 6 get through.
    task automatic test_glitch();
        logic [3:0] exp;
        int         len  [4];
        logic [3:0] bitv [4];
        int         lo;
        int         hi;
        len[0] = 2; bitv[0] = 4'h1;
        len[1] = 3; bitv[1] = 4'h2;
        len[2] = 4; bitv[2] = 4'h4;
        len[3] = 6; bitv[3] = 4'h1;
        for (int p = 0; p < 4; p++) begin
            // Accepted pulse: set at edge 5, cleared 4 mismatch edges after s2 drops.
            lo = 5;
            hi = len[p] + 4;
            for (int i = 0; i < 14; i++)
                sb.push_back((len[p] >= 4 && i >= lo && i <= hi) ? bitv[p] : 4'h0);
            for (int i = 0; i < 14; i++) begin
                @(negedge clk);
                sw = (i < len[p]) ? bitv[p] : 4'h0;
                @(posedge clk); #1;
                exp = sb.pop_front();
                checks++;
                if (led !== exp) begin
                    errors++;
                    $display("FAIL glitch len %0d cyc %0d: led=%b expected %b", len[p], i, led, exp);
                end
            end
        end
    endtask

    // bit0 held while bit3 glitches; bit3 must stay 0 and bit0 timing is unaffected.
    task automatic test_independent();
        logic [3:0] exp;
        for (int i = 0; i < 20; i++) sb.push_back((i >= 5 && i <= 14) ? 4'h1 : 4'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sw = ((i < 10) ? 4'h1 : 4'h0) | ((i < 3) ? 4'h8 : 4'h0);
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (led !== exp) begin
                errors++;
                $display("FAIL independent cyc %0d: led=%b expected %b", i, led, exp);
            end
        end
    endtask

    task automatic test_param1();
        logic [3:0] exp;
        for (int i = 0; i < 10; i++) sb.push_back((i >= 2 && i <= 7) ? 4'h6 : 4'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sw1 = (i < 6) ? 4'h6 : 4'h0;
            @(posedge clk); #1;
            exp = sb.pop_front();
            checks++;
            if (led1 !== exp) begin
                errors++;
                $display("FAIL param1 edge k+%0d: led1=%b expected %b", i, led1, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_latency();
        test_sequence();
        test_async_reset();
        test_reset_midcount();
        test_glitch();
        test_independent();
        test_param1();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
